// File: rtl/turn_signal_conditioner.sv
// turn_signal_conditioner
//   Front end for the tail-light sequencer. Synchronizes and debounces the raw left lever,
//   right lever and hazard push-button contacts, resolves conflicting lever requests and
//   adds a hazard mode that requests both sides at once. Each hazard press toggles hazard.
//
//   Optional feature macro: TURN_AUTOCANCEL_EN
//     defined   - a timeout counter runs in LEFT/RIGHT; after TIMEOUT_CYCLES the request is
//                 dropped into LOCKOUT until both levers are released.
//     undefined - no timeout counter; LOCKOUT is unreachable; LEFT/RIGHT persist while held.
//
// Ports
//   clk              in   clock, all logic on rising edge
//   reset            in   synchronous, active-low reset
//   i_sw_left_raw    in   left lever contact (asynchronous, may bounce)
//   i_sw_right_raw   in   right lever contact (asynchronous, may bounce)
//   i_sw_hazard_raw  in   hazard push-button (asynchronous, may bounce)
//   o_left           out  registered left request to sequencer
//   o_right          out  registered right request to sequencer
//   o_hazard_active  out  registered, high while in HAZARD

module turn_signal_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sw_left_raw,
    input  logic i_sw_right_raw,
    input  logic i_sw_hazard_raw,
    output logic o_left,
    output logic o_right,
    output logic o_hazard_active
);

    // Elaboration-time parameter sanity checks.
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    // Input lanes: 0 = left, 1 = right, 2 = hazard.
    localparam int unsigned NumIn  = 3;
    localparam int unsigned IdxL   = 0;
    localparam int unsigned IdxR   = 1;
    localparam int unsigned IdxH   = 2;
    localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLeft    = 3'd1,
        StRight   = 3'd2,
        StHazard  = 3'd3,
        StLockout = 3'd4
    } state_e;

    logic [NumIn-1:0]                  w_raw;
    logic [NumIn-1:0][SYNC_STAGES-1:0] r_sync;
    logic [NumIn-1:0]                  w_sync;
    logic [NumIn-1:0]                  r_db;
    logic [NumIn-1:0]                  w_db_d;
    logic [NumIn-1:0][CntW-1:0]        r_cnt;
    logic [NumIn-1:0][CntW-1:0]        w_cnt_d;
    logic                              r_hz_prev;
    logic                              w_hz_press;
    logic                              w_db_left;
    logic                              w_db_right;
    logic                              w_tmo_hit;

    state_e r_state;
    state_e w_next;
    logic   r_left;
    logic   r_right;
    logic   r_hazard;

    assign w_raw = {i_sw_hazard_raw, i_sw_right_raw, i_sw_left_raw};

    // ------------------------------------------------------------------
    // Synchronizer chains
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            for (int i = 0; i < NumIn; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
            end
        end
    end

    always_comb begin
        w_sync = '0;
        for (int i = 0; i < NumIn; i++) begin
            w_sync[i] = r_sync[i][SYNC_STAGES-1];
        end
    end

    // ------------------------------------------------------------------
    // Debouncers: db follows sync only after DEBOUNCE_CYCLES consecutive
    // disagreeing cycles; any agreement restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        w_db_d  = r_db;
        w_cnt_d = '0;
        for (int i = 0; i < NumIn; i++) begin
            if (w_sync[i] != r_db[i]) begin
                if (r_cnt[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    w_db_d[i]  = w_sync[i];
                    w_cnt_d[i] = '0;
                end else begin
                    w_cnt_d[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_db      <= '0;
            r_cnt     <= '0;
            r_hz_prev <= 1'b0;
        end else begin
            r_db      <= w_db_d;
            r_cnt     <= w_cnt_d;
            r_hz_prev <= r_db[IdxH];
        end
    end

    assign w_db_left  = r_db[IdxL];
    assign w_db_right = r_db[IdxR];
    // Rising edge of debounced hazard only; release is ignored.
    assign w_hz_press = r_db[IdxH] & ~r_hz_prev;

    // ------------------------------------------------------------------
    // Optional auto-cancel timeout
    // ------------------------------------------------------------------
`ifdef TURN_AUTOCANCEL_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] r_tmo;
    logic [TmoW-1:0] w_tmo_d;

    assign w_tmo_hit = (r_tmo == TmoW'(TIMEOUT_CYCLES - 1));

    // Counts edges spent in LEFT/RIGHT; zero on entry or anywhere else.
    always_comb begin
        w_tmo_d = '0;
        if (((r_state == StLeft) || (r_state == StRight)) && (w_next == r_state)) begin
            w_tmo_d = r_tmo + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= w_tmo_d;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        if (w_hz_press) begin
            // Hazard toggle outranks any simultaneous lever change.
            w_next = (r_state == StHazard) ? StIdle : StHazard;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_db_left && !w_db_right) begin
                        w_next = StLeft;
                    end else if (w_db_right && !w_db_left) begin
                        w_next = StRight;
                    end
                end
                StLeft: begin
                    // Releasing left always passes through IDLE, even if right is held.
                    if (!w_db_left) begin
                        w_next = StIdle;
                    end else if (w_tmo_hit) begin
                        w_next = StLockout;
                    end
                end
                StRight: begin
                    if (!w_db_right) begin
                        w_next = StIdle;
                    end else if (w_tmo_hit) begin
                        w_next = StLockout;
                    end
                end
                StHazard: begin
                    w_next = StHazard;
                end
                StLockout: begin
                    if (!w_db_left && !w_db_right) begin
                        w_next = StIdle;
                    end
                end
                default: begin
                    w_next = StIdle;
                end
            endcase
        end
    end

    // Outputs are a registered decode of the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= StIdle;
            r_left   <= 1'b0;
            r_right  <= 1'b0;
            r_hazard <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_left   <= (w_next == StLeft) || (w_next == StHazard);
            r_right  <= (w_next == StRight) || (w_next == StHazard);
            r_hazard <= (w_next == StHazard);
        end
    end

    assign o_left          = r_left;
    assign o_right         = r_right;
    assign o_hazard_active = r_hazard;

endmodule
